// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution row feeder.
//   DATA_W  : default pixel width, matches the PE row input width
//   state_t : feeder sequencing states
//   clog2   : counter width helper, never returns less than 1
package conv_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/conv_row_feeder_if.sv
// Pixel stream in, aligned row triplet out.
//   pix_in/pix_valid/pix_ready : raster pixel stream with ready
//   R1/R2/R3                   : rows r-2, r-1, r at the same column
//   sel                        : column phase (col mod 3)
//   out_valid                  : R1..R3 and sel are valid this cycle
//   frame_done                 : one-cycle end-of-frame pulse
// master = pixel source / PE array side, slave = feeder.
interface conv_row_feeder_if #(
   parameter int DATA_W = conv_pkg::DATA_W
);
   logic [DATA_W-1:0] pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic [DATA_W-1:0] R1;
   logic [DATA_W-1:0] R2;
   logic [DATA_W-1:0] R3;
   logic [1:0]        sel;
   logic              out_valid;
   logic              frame_done;

   modport master (
      output pix_in, pix_valid,
      input  pix_ready, R1, R2, R3, sel, out_valid, frame_done
   );

   modport slave (
      input  pix_in, pix_valid,
      output pix_ready, R1, R2, R3, sel, out_valid, frame_done
   );
endinterface

// File: rtl/conv_line_buffer.sv
// Single-port line buffer: DEPTH x WIDTH, synchronous write, combinational
// read at the same address (a same-cycle read returns the pre-write word).
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : read data
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // No reset: FILL overwrites every word before it is ever read out.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/conv_row_feeder.sv
// Raster pixel stream to vertically aligned 3-row samples for the 3x3 PE array.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : conv_row_feeder_if.slave (pixel stream in, row triplet out)
//
// state  | meaning
// FILL   | rows 0..1 being stored, no output
// STREAM | rows 2..IMG_H-1, one output per accepted pixel
// DONE   | single bubble after last pixel, frame_done high, not ready
module conv_row_feeder #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int DATA_W = conv_pkg::DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   conv_row_feeder_if.slave   bus
);
   import conv_pkg::*;

   localparam int CW = clog2(IMG_W);
   localparam int RW = clog2(IMG_H);

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q;
   logic [RW-1:0]     row_q;
   logic [1:0]        phase_q;
   logic              pix_ready_q;
   logic              frame_done_q;
   logic              accept;
   logic              last_col;
   logic              last_row;
   logic [DATA_W-1:0] old_rd, new_rd;
   logic [DATA_W-1:0] r1_q, r2_q, r3_q;
   logic [1:0]        sel_q;
   logic              out_valid_q;

   assign accept   = bus.pix_valid && pix_ready_q;
   assign last_col = (col_q == CW'(IMG_W - 1));
   assign last_row = (row_q == RW'(IMG_H - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (accept && last_col && row_q == RW'(1)) state_d = STREAM;
         STREAM:  if (accept && last_col && last_row)        state_d = DONE;
         DONE:    state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // pix_ready and frame_done are registered decodes of the next state so
   // neither ever depends combinationally on pix_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FILL;
         pix_ready_q  <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_ready_q  <= (state_d != DONE);
         frame_done_q <= (state_d == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || state_q == DONE) begin
         col_q   <= '0;
         row_q   <= '0;
         phase_q <= '0;
      end else if (accept) begin
         if (last_col) begin
            col_q   <= '0;
            phase_q <= '0;
            row_q   <= last_row ? '0 : row_q + RW'(1);
         end else begin
            col_q   <= col_q + CW'(1);
            phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
         end
      end
   end

   // Both buffers shift one row per accept: old takes new's word, new takes
   // the incoming pixel; reads see the pre-write contents.
   conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb_old (
      .clk   (clk),
      .we    (accept),
      .addr  (col_q),
      .wdata (new_rd),
      .rdata (old_rd)
   );

   conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb_new (
      .clk   (clk),
      .we    (accept),
      .addr  (col_q),
      .wdata (bus.pix_in),
      .rdata (new_rd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r1_q        <= '0;
         r2_q        <= '0;
         r3_q        <= '0;
         sel_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= accept && (state_q == STREAM);
         if (accept && state_q == STREAM) begin
            r1_q  <= old_rd;
            r2_q  <= new_rd;
            r3_q  <= bus.pix_in;
            sel_q <= phase_q;
         end
      end
   end

   assign bus.pix_ready  = pix_ready_q;
   assign bus.frame_done = frame_done_q;
   assign bus.R1         = r1_q;
   assign bus.R2         = r2_q;
   assign bus.R3         = r3_q;
   assign bus.sel        = sel_q;
   assign bus.out_valid  = out_valid_q;

endmodule
